// File: rtl/ddr2_arb_pkg.sv
// Shared command encodings, FSM states and tag-sizing helpers for the
// DDR2 requester arbiter and its return-tag queue.
package ddr2_arb_pkg;

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_SCR  = 3'b001;
   localparam logic [2:0] CMD_SCW  = 3'b010;
   localparam logic [2:0] CMD_BLR  = 3'b011;
   localparam logic [2:0] CMD_BLW  = 3'b100;
   localparam logic [2:0] CMD_ATM0 = 3'b101;
   localparam logic [2:0] CMD_ATM1 = 3'b110;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   function automatic logic needs_tag(input logic [2:0] cmd);
      return (cmd == CMD_SCR) || (cmd == CMD_BLR) ||
             (cmd == CMD_ATM0) || (cmd == CMD_ATM1);
   endfunction

   function automatic logic cmd_is_valid(input logic [2:0] cmd);
      return (cmd != CMD_NOP) && (cmd != 3'b111);
   endfunction

   // Number of words the controller will return for a command.
   function automatic logic [5:0] ret_words(input logic [2:0] cmd, input logic [1:0] sz);
      logic [5:0] n;
      n = 6'd0;
      if (cmd == CMD_BLR) begin
         n = {({1'b0, sz} + 3'd1), 3'b000};
      end else if (needs_tag(cmd)) begin
         n = 6'd1;
      end
      return n;
   endfunction

   function automatic logic [5:0] burst_last(input logic [1:0] sz);
      return {1'b0, sz, 3'b111};
   endfunction

endpackage

// File: rtl/ddr2_tag_queue.sv
// In-order queue of {owner id, remaining return words}; the head entry is
// decremented once per returned word and popped when its count runs out.
module ddr2_tag_queue
   import ddr2_arb_pkg::*;
#(
   parameter int IDW   = 1,
   parameter int DEPTH = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  logic [IDW-1:0] push_id_i,
   input  logic [5:0]     push_cnt_i,
   input  logic           dec_i,
   output logic [IDW-1:0] head_id_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
   logic [IDW-1:0] id_mem  [DEPTH];
   logic [5:0]     cnt_mem [DEPTH];
   logic           do_push, do_dec, do_pop;

   assign empty_o   = (wr_q == rd_q);
   assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign head_id_o = id_mem[rd_q[AW-1:0]];

   assign do_push = push_i & ~full_o;
   assign do_dec  = dec_i & ~empty_o;
   assign do_pop  = do_dec & (cnt_mem[rd_q[AW-1:0]] == 6'd1);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Push and decrement never share a slot: a push needs a free slot, a decrement a live head.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         id_mem[wr_q[AW-1:0]]  <= push_id_i;
         cnt_mem[wr_q[AW-1:0]] <= push_cnt_i;
      end
      if (do_dec) begin
         cnt_mem[rd_q[AW-1:0]] <= cnt_mem[rd_q[AW-1:0]] - 6'd1;
      end
   end

endmodule

// File: rtl/ddr2_req_arbiter.sv
// Round-robin front end sharing the DDR2 controller host port among NREQ
// requesters, streaming block-write beats and routing returned words home.
module ddr2_req_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int IDW      = 1,
   parameter int TAGDEPTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NREQ-1:0]    req_valid_i,
   input  logic [3*NREQ-1:0]  req_cmd_i,
   input  logic [25*NREQ-1:0] req_addr_i,
   input  logic [2*NREQ-1:0]  req_sz_i,
   input  logic [3*NREQ-1:0]  req_op_i,
   input  logic [16*NREQ-1:0] req_din_i,
   output logic [NREQ-1:0]    req_ack_o,
   output logic [NREQ-1:0]    req_dready_o,
   output logic [NREQ-1:0]    rsp_valid_o,
   output logic [15:0]        rsp_data_o,
   output logic [24:0]        rsp_addr_o,
   output logic [2:0]         ctl_cmd_o,
   output logic [24:0]        ctl_addr_o,
   output logic [1:0]         ctl_sz_o,
   output logic [2:0]         ctl_op_o,
   output logic [15:0]        ctl_din_o,
   input  logic               ctl_notfull_i,
   input  logic               ctl_ready_i,
   input  logic [15:0]        ctl_dout_i,
   input  logic [24:0]        ctl_raddr_i,
   input  logic               ctl_validout_i,
   output logic               err_orphan_o
);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [15:0]    rsp_data_q;
   logic [24:0]    rsp_addr_q;
   logic           err_q;

   logic [2:0]  cmd_a  [NREQ];
   logic [24:0] addr_a [NREQ];
   logic [1:0]  sz_a   [NREQ];
   logic [2:0]  op_a   [NREQ];
   logic [15:0] din_a  [NREQ];

   logic           issue_ok;
   logic [NREQ-1:0] elig;
   logic           win_found;
   logic [IDW-1:0] win_id, scan_idx;

   logic           tq_push, tq_dec, tq_full, tq_empty;
   logic [IDW-1:0] tq_push_id, tq_head_id;
   logic [5:0]     tq_push_cnt;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign cmd_a[g]  = req_cmd_i[3*g +: 3];
      assign addr_a[g] = req_addr_i[25*g +: 25];
      assign sz_a[g]   = req_sz_i[2*g +: 2];
      assign op_a[g]   = req_op_i[3*g +: 3];
      assign din_a[g]  = req_din_i[16*g +: 16];
   end

   assign issue_ok = ctl_ready_i & ctl_notfull_i;

   // Invalid commands are always eligible so they can be flushed with an ack.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_valid_i[i] &
                   (~cmd_is_valid(cmd_a[i]) |
                    (issue_ok & (~needs_tag(cmd_a[i]) | ~tq_full)));
      end
   end

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!win_found && elig[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      req_ack_o    = '0;
      req_dready_o = '0;
      ctl_cmd_o    = CMD_NOP;
      ctl_addr_o   = '0;
      ctl_sz_o     = '0;
      ctl_op_o     = '0;
      ctl_din_o    = '0;
      tq_push      = 1'b0;
      tq_push_id   = '0;
      tq_push_cnt  = '0;
      if (rst_ni) begin
         unique case (state_q)
            ST_ARB: begin
               if (win_found) begin
                  req_ack_o[win_id] = 1'b1;
                  ptr_d = IDW'((int'(win_id) + 1) % NREQ);
                  if (cmd_is_valid(cmd_a[win_id])) begin
                     ctl_cmd_o  = cmd_a[win_id];
                     ctl_addr_o = addr_a[win_id];
                     ctl_sz_o   = sz_a[win_id];
                     ctl_op_o   = op_a[win_id];
                     ctl_din_o  = din_a[win_id];
                     if (needs_tag(cmd_a[win_id])) begin
                        tq_push     = 1'b1;
                        tq_push_id  = win_id;
                        tq_push_cnt = ret_words(cmd_a[win_id], sz_a[win_id]);
                     end
                     if (cmd_a[win_id] == CMD_BLW) begin
                        owner_d = win_id;
                        cnt_d   = burst_last(sz_a[win_id]);
                        state_d = (burst_last(sz_a[win_id]) != 6'd0) ? ST_BURST : ST_ARB;
                     end
                  end
               end
            end
            ST_BURST: begin
               ctl_din_o = din_a[owner_q];
               if (ctl_notfull_i) begin
                  req_dready_o[owner_q] = 1'b1;
                  cnt_d = cnt_q - 6'd1;
                  if (cnt_q == 6'd1) state_d = ST_ARB;
               end
            end
            default: state_d = ST_ARB;
         endcase
      end
   end

   assign tq_dec = ctl_validout_i & ~tq_empty;

   always_comb begin
      rsp_valid_d = '0;
      if (tq_dec) rsp_valid_d[tq_head_id] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_ARB;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_addr_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         if (tq_dec) begin
            rsp_data_q <= ctl_dout_i;
            rsp_addr_q <= ctl_raddr_i;
         end
         if (ctl_validout_i && tq_empty) err_q <= 1'b1;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_addr_o   = rsp_addr_q;
   assign err_orphan_o = err_q;

   ddr2_tag_queue #(
      .IDW   (IDW),
      .DEPTH (TAGDEPTH)
   ) u_tag_queue (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (tq_push),
      .push_id_i  (tq_push_id),
      .push_cnt_i (tq_push_cnt),
      .dec_i      (tq_dec),
      .head_id_o  (tq_head_id),
      .full_o     (tq_full),
      .empty_o    (tq_empty)
   );

endmodule

// File: tb/tb_ddr2_req_arbiter.sv
// Scenario-driven bench for ddr2_req_arbiter; returned words are checked
// against a scoreboard filled as the controller return path is driven.
module tb_ddr2_req_arbiter;
   import ddr2_arb_pkg::*;

   localparam int NREQ     = 2;
   localparam int IDW      = 1;
   localparam int TAGDEPTH = 8;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [NREQ-1:0]    req_valid_i;
   logic [3*NREQ-1:0]  req_cmd_i;
   logic [25*NREQ-1:0] req_addr_i;
   logic [2*NREQ-1:0]  req_sz_i;
   logic [3*NREQ-1:0]  req_op_i;
   logic [16*NREQ-1:0] req_din_i;
   logic [NREQ-1:0]    req_ack_o, req_dready_o, rsp_valid_o;
   logic [15:0]        rsp_data_o;
   logic [24:0]        rsp_addr_o;
   logic [2:0]         ctl_cmd_o;
   logic [24:0]        ctl_addr_o;
   logic [1:0]         ctl_sz_o;
   logic [2:0]         ctl_op_o;
   logic [15:0]        ctl_din_o;
   logic               ctl_notfull_i, ctl_ready_i, ctl_validout_i;
   logic [15:0]        ctl_dout_i;
   logic [24:0]        ctl_raddr_i;
   logic               err_orphan_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NREQ-1:0] vec;
      logic [15:0]     data;
      logic [24:0]     addr;
   } rsp_t;
   rsp_t sb[$];

   always #5 clk_i = ~clk_i;

   ddr2_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TAGDEPTH(TAGDEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i),
      .req_sz_i(req_sz_i), .req_op_i(req_op_i), .req_din_i(req_din_i),
      .req_ack_o(req_ack_o), .req_dready_o(req_dready_o), .rsp_valid_o(rsp_valid_o),
      .rsp_data_o(rsp_data_o), .rsp_addr_o(rsp_addr_o),
      .ctl_cmd_o(ctl_cmd_o), .ctl_addr_o(ctl_addr_o), .ctl_sz_o(ctl_sz_o),
      .ctl_op_o(ctl_op_o), .ctl_din_o(ctl_din_o),
      .ctl_notfull_i(ctl_notfull_i), .ctl_ready_i(ctl_ready_i),
      .ctl_dout_i(ctl_dout_i), .ctl_raddr_i(ctl_raddr_i),
      .ctl_validout_i(ctl_validout_i), .err_orphan_o(err_orphan_o)
   );

   task automatic set_req(input int i, input logic [2:0] cmd, input logic [24:0] addr,
                          input logic [1:0] sz, input logic [15:0] din);
      req_cmd_i[3*i +: 3]   = cmd;
      req_addr_i[25*i +: 25] = addr;
      req_sz_i[2*i +: 2]    = sz;
      req_op_i[3*i +: 3]    = 3'b000;
      req_din_i[16*i +: 16] = din;
   endtask

   task automatic reset_dut();
      rst_ni         = 1'b0;
      req_valid_i    = '0;
      req_cmd_i      = '0;
      req_addr_i     = '0;
      req_sz_i       = '0;
      req_op_i       = '0;
      req_din_i      = '0;
      ctl_notfull_i  = 1'b1;
      ctl_ready_i    = 1'b1;
      ctl_validout_i = 1'b0;
      ctl_dout_i     = '0;
      ctl_raddr_i    = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      reset_dut();
      rst_ni = 1'b0;
      set_req(0, CMD_SCW, 25'h11, 2'd0, 16'h1234);
      set_req(1, CMD_SCW, 25'h22, 2'd0, 16'h5678);
      req_valid_i = 2'b11;
      #3;
      checks++; if (ctl_cmd_o !== 3'b000) begin errors++; $display("[TB] FAIL reset_cmd got %b expected 000", ctl_cmd_o); end
      checks++; if (req_ack_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack got %b expected 00", req_ack_o); end
      checks++; if (req_dready_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_dready got %b expected 00", req_dready_o); end
      checks++; if (rsp_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b expected 00", rsp_valid_o); end
      checks++; if (rsp_data_o !== 16'h0 || rsp_addr_o !== 25'h0) begin errors++; $display("[TB] FAIL reset_rsp_bus got %h/%h expected 0/0", rsp_data_o, rsp_addr_o); end
      checks++; if (err_orphan_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", err_orphan_o); end
      checks++; if (ctl_din_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_din got %h expected 0", ctl_din_o); end
   endtask

   task automatic test_rr_scw();
      int exp_id;
      logic [1:0] exp_ack;
      logic [15:0] exp_din;
      reset_dut();
      set_req(0, CMD_SCW, 25'h10, 2'd0, 16'h1111);
      set_req(1, CMD_SCW, 25'h20, 2'd0, 16'h2222);
      req_valid_i = 2'b11;
      exp_id = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         exp_ack = 2'b01 << exp_id;
         exp_din = (exp_id == 0) ? 16'h1111 : 16'h2222;
         checks++; if (req_ack_o !== exp_ack) begin errors++; $display("[TB] FAIL rr_ack cycle %0d got %b expected %b", c, req_ack_o, exp_ack); end
         checks++; if (ctl_cmd_o !== CMD_SCW) begin errors++; $display("[TB] FAIL rr_cmd cycle %0d got %b expected 010", c, ctl_cmd_o); end
         checks++; if (ctl_din_o !== exp_din) begin errors++; $display("[TB] FAIL rr_din cycle %0d got %h expected %h", c, ctl_din_o, exp_din); end
         exp_id = 1 - exp_id;
         @(posedge clk_i); #1;
      end
      req_valid_i = '0;
   endtask

   task automatic test_blw_burst();
      int beats, dready_n;
      bit ack1_seen, stalled, in_stall;
      reset_dut();
      set_req(0, CMD_BLW, 25'h300, 2'd1, 16'hA000);
      set_req(1, CMD_SCW, 25'h400, 2'd0, 16'hB000);
      req_valid_i = 2'b11;
      beats = 0; dready_n = 0; ack1_seen = 0; stalled = 0; in_stall = 0;
      for (int c = 0; c < 40 && !ack1_seen; c++) begin
         @(negedge clk_i);
         if (in_stall) begin
            checks++; if (req_dready_o !== 2'b00) begin errors++; $display("[TB] FAIL burst_stall got dready %b expected 00", req_dready_o); end
         end
         if (req_ack_o[0]) begin
            checks++; if (ctl_cmd_o !== CMD_BLW || ctl_din_o !== 16'hA000) begin errors++; $display("[TB] FAIL burst_accept got %b/%h expected 100/a000", ctl_cmd_o, ctl_din_o); end
            beats++;
         end
         if (req_dready_o[0]) begin
            checks++; if (ctl_din_o !== 16'hA000 + 16'(beats)) begin errors++; $display("[TB] FAIL burst_din got %h expected %h", ctl_din_o, 16'hA000 + 16'(beats)); end
            beats++;
            dready_n++;
         end
         if (req_ack_o[1]) begin
            ack1_seen = 1;
            checks++; if (beats != 16) begin errors++; $display("[TB] FAIL burst_ack1_early got beats %0d expected 16", beats); end
         end
         @(posedge clk_i); #1;
         req_din_i[15:0] = 16'hA000 + 16'(beats);
         if (beats > 0) req_valid_i[0] = 1'b0;
         in_stall = 0;
         if (beats == 5 && !stalled) begin
            ctl_notfull_i = 1'b0; stalled = 1; in_stall = 1;
         end else begin
            ctl_notfull_i = 1'b1;
         end
      end
      req_valid_i = '0;
      checks++; if (!ack1_seen) begin errors++; $display("[TB] FAIL burst_timeout got no ack1 expected ack1"); end
      checks++; if (beats != 16) begin errors++; $display("[TB] FAIL burst_beats got %0d expected 16", beats); end
      checks++; if (dready_n != 15) begin errors++; $display("[TB] FAIL burst_dready_count got %0d expected 15", dready_n); end
   endtask

   task automatic test_return_path();
      bit got;
      int n0, n1;
      rsp_t e, a;
      reset_dut();
      set_req(0, CMD_BLR, 25'h1000, 2'd0, 16'h0);
      req_valid_i = 2'b01;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk_i);
         if (req_ack_o[0]) got = 1;
         @(posedge clk_i); #1;
      end
      checks++; if (!got) begin errors++; $display("[TB] FAIL ret_blr_ack got none expected ack0"); end
      set_req(1, CMD_SCR, 25'h2000, 2'd0, 16'h0);
      req_valid_i = 2'b10;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk_i);
         if (req_ack_o[1]) got = 1;
         @(posedge clk_i); #1;
      end
      checks++; if (!got) begin errors++; $display("[TB] FAIL ret_scr_ack got none expected ack1"); end
      req_valid_i = '0;
      n0 = 0; n1 = 0;
      for (int c = 0; c < 11; c++) begin
         if (c < 9) begin
            ctl_validout_i = 1'b1;
            ctl_dout_i     = 16'h5000 + 16'(c);
            ctl_raddr_i    = 25'h100 + 25'(c);
            e.vec  = (c < 8) ? 2'b01 : 2'b10;
            e.data = ctl_dout_i;
            e.addr = ctl_raddr_i;
            sb.push_back(e);
         end else begin
            ctl_validout_i = 1'b0;
         end
         @(negedge clk_i);
         checks++;
         if ((rsp_valid_o !== 2'b00) != (c >= 1 && c <= 9)) begin
            errors++; $display("[TB] FAIL ret_latency cycle %0d got rsp_valid %b", c, rsp_valid_o);
         end
         if (rsp_valid_o !== 2'b00 && sb.size() > 0) begin
            a = sb.pop_front();
            if (rsp_valid_o[0]) n0++;
            if (rsp_valid_o[1]) n1++;
            checks++; if (rsp_valid_o !== a.vec) begin errors++; $display("[TB] FAIL ret_owner got %b expected %b", rsp_valid_o, a.vec); end
            checks++; if (rsp_data_o !== a.data) begin errors++; $display("[TB] FAIL ret_data got %h expected %h", rsp_data_o, a.data); end
            checks++; if (rsp_addr_o !== a.addr) begin errors++; $display("[TB] FAIL ret_addr got %h expected %h", rsp_addr_o, a.addr); end
         end
         @(posedge clk_i); #1;
      end
      ctl_validout_i = 1'b0;
      checks++; if (sb.size() != 0 || n0 != 8 || n1 != 1) begin errors++; $display("[TB] FAIL ret_counts got left %0d n0 %0d n1 %0d expected 0/8/1", sb.size(), n0, n1); end
      sb.delete();
   endtask

   task automatic test_tag_full();
      int n;
      reset_dut();
      set_req(0, CMD_SCR, 25'h3000, 2'd0, 16'h0);
      req_valid_i = 2'b01;
      n = 0;
      for (int c = 0; c < 20 && n < 8; c++) begin
         @(negedge clk_i);
         if (req_ack_o[0]) n++;
         @(posedge clk_i); #1;
      end
      checks++; if (n != 8) begin errors++; $display("[TB] FAIL full_fill got %0d expected 8", n); end
      @(negedge clk_i);
      checks++; if (req_ack_o !== 2'b00 || ctl_cmd_o !== CMD_NOP) begin errors++; $display("[TB] FAIL full_stall got %b/%b expected 00/000", req_ack_o, ctl_cmd_o); end
      @(posedge clk_i); #1;
      set_req(1, CMD_SCW, 25'h3100, 2'd0, 16'h7777);
      req_valid_i = 2'b11;
      @(negedge clk_i);
      checks++; if (req_ack_o !== 2'b10 || ctl_cmd_o !== CMD_SCW) begin errors++; $display("[TB] FAIL full_fallthrough got %b/%b expected 10/010", req_ack_o, ctl_cmd_o); end
      @(posedge clk_i); #1;
      req_valid_i    = 2'b01;
      ctl_validout_i = 1'b1;
      ctl_dout_i     = 16'h6000;
      ctl_raddr_i    = 25'h3000;
      @(negedge clk_i);
      checks++; if (req_ack_o !== 2'b00) begin errors++; $display("[TB] FAIL full_still got %b expected 00", req_ack_o); end
      @(posedge clk_i); #1;
      ctl_validout_i = 1'b0;
      @(negedge clk_i);
      checks++; if (req_ack_o !== 2'b01) begin errors++; $display("[TB] FAIL full_release got %b expected 01", req_ack_o); end
      checks++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 16'h6000) begin errors++; $display("[TB] FAIL full_rsp got %b/%h expected 01/6000", rsp_valid_o, rsp_data_o); end
      @(posedge clk_i); #1;
      req_valid_i = '0;
   endtask

   task automatic test_orphan_and_reset();
      reset_dut();
      @(negedge clk_i);
      checks++; if (err_orphan_o !== 1'b0) begin errors++; $display("[TB] FAIL orphan_init got %b expected 0", err_orphan_o); end
      @(posedge clk_i); #1;
      ctl_validout_i = 1'b1;
      ctl_dout_i     = 16'hDEAD;
      ctl_raddr_i    = 25'h777;
      @(posedge clk_i); #1;
      ctl_validout_i = 1'b0;
      @(negedge clk_i);
      checks++; if (err_orphan_o !== 1'b1) begin errors++; $display("[TB] FAIL orphan_err got %b expected 1", err_orphan_o); end
      checks++; if (rsp_valid_o !== 2'b00 || rsp_data_o !== 16'h0) begin errors++; $display("[TB] FAIL orphan_rsp got %b/%h expected 00/0000", rsp_valid_o, rsp_data_o); end
      @(posedge clk_i); #1;
      set_req(0, CMD_BLW, 25'h500, 2'd3, 16'hC000);
      req_valid_i = 2'b01;
      @(negedge clk_i);
      checks++; if (req_ack_o !== 2'b01) begin errors++; $display("[TB] FAIL rstburst_ack got %b expected 01", req_ack_o); end
      @(posedge clk_i); #1;
      set_req(1, CMD_SCW, 25'h600, 2'd0, 16'h9999);
      req_valid_i = 2'b10;
      @(negedge clk_i);
      checks++; if (req_dready_o !== 2'b01 || req_ack_o !== 2'b00) begin errors++; $display("[TB] FAIL rstburst_beat got %b/%b expected 01/00", req_dready_o, req_ack_o); end
      #2 rst_ni = 1'b0;
      #1;
      checks++; if (ctl_cmd_o !== 3'b000 || ctl_din_o !== 16'h0) begin errors++; $display("[TB] FAIL rstburst_ctl got %b/%h expected 000/0000", ctl_cmd_o, ctl_din_o); end
      checks++; if (req_dready_o !== 2'b00 || req_ack_o !== 2'b00) begin errors++; $display("[TB] FAIL rstburst_hs got %b/%b expected 00/00", req_dready_o, req_ack_o); end
      checks++; if (err_orphan_o !== 1'b0 || rsp_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL rstburst_ret got %b/%b expected 0/00", err_orphan_o, rsp_valid_o); end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      checks++; if (req_ack_o !== 2'b10 || ctl_cmd_o !== CMD_SCW || req_dready_o !== 2'b00) begin errors++; $display("[TB] FAIL rstburst_arb got %b/%b/%b expected 10/010/00", req_ack_o, ctl_cmd_o, req_dready_o); end
      @(posedge clk_i); #1;
      req_valid_i = '0;
      @(negedge clk_i);
      checks++; if (ctl_cmd_o !== 3'b000 || req_dready_o !== 2'b00) begin errors++; $display("[TB] FAIL rstburst_idle got %b/%b expected 000/00", ctl_cmd_o, req_dready_o); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_rr_scw();
      test_blw_burst();
      test_return_path();
      test_tag_full();
      test_orphan_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr2_req_arbiter.md
Name: ddr2_req_arbiter

Overview:
- Round-robin front-end that shares the single host command/data interface of the DDR2 controller between NREQ requesters.
- Issues commands (cmd/addr/sz/op/din) and streams block-write data beats.
- Records the owner of every data-returning command in an in-order tag queue and routes each returned word (dout/raddr on validout) back to its owner.
- Sits between the requester clients and the controller's host port.

Parameters:
- NREQ, 2, number of requesters.
- IDW, 1, requester ID width; must satisfy 2**IDW >= NREQ.
- TAGDEPTH, 8, depth of the outstanding-return tag queue (power of 2).

Ports:
- clk  in  1  system clock (same clock as the controller).
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command pending.
- req_cmd  in  3*NREQ  packed cmd per requester. Encodings: 001 SCR, 010 SCW, 011 BLR, 100 BLW, 101/110 ATOMIC.
- req_addr  in  25*NREQ  packed address.
- req_sz  in  2*NREQ  packed block size.
- req_op  in  3*NREQ  packed atomic op.
- req_din  in  16*NREQ  packed write data.
- req_ack  out  NREQ  one-cycle pulse: the command was accepted by the controller.
- req_dready  out  NREQ  one-cycle pulse: a block-write data beat was consumed.
- rsp_valid  out  NREQ  one-cycle pulse: return word for this requester.
- rsp_data  out  16  return data, shared by all requesters.
- rsp_addr  out  25  return address, shared by all requesters.
- ctl_cmd  out  3  controller command; 000 = NOP.
- ctl_addr  out  25  controller address.
- ctl_sz  out  2  controller block size.
- ctl_op  out  3  controller atomic op.
- ctl_din  out  16  controller write data.
- ctl_notfull  in  1  controller can accept a command or data beat.
- ctl_ready  in  1  controller initialisation done.
- ctl_dout  in  16  controller return data.
- ctl_raddr  in  25  controller return address.
- ctl_validout  in  1  controller return word valid.
- err_orphan  out  1  sticky: a return word arrived with the tag queue empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to ARB.
  - RR pointer goes to 0.
  - Tag queue is emptied.
  - Beat counter goes to 0.
  - All outputs go to 0: ctl_cmd=000, ack/dready/rsp_valid=0, rsp_data/rsp_addr=0, err_orphan=0.
  - A reset in the middle of a burst abandons the burst; no further beats are driven.
- Definitions:
  - issue_ok = ctl_ready & ctl_notfull.
  - needs_tag = cmd in {001, 011, 101, 110}.
  - ret_words = 1 for SCR/ATOMIC; 8*(sz+1) for BLR (6-bit count, max 32).
- State ARB:
  - Winner = first i with req_valid[i], searching from the RR pointer upward with wrap.
  - A winner is eligible when issue_ok holds and, if needs_tag, the tag queue is not full.
  - If no requester is eligible: ctl_cmd=000.
  - If eligible (same cycle, combinational from state and inputs):
    - ctl_* = winner fields; req_ack[winner]=1.
    - If needs_tag: push {winner, ret_words}.
    - RR pointer <= winner+1, mod NREQ.
  - A BLW win additionally sets beat counter <= 8*(sz+1)-1, and next state is BURST if the counter is nonzero.
  - SCW and the first BLW beat carry req_din on ctl_din in the accept cycle.
  - Invalid cmds (000, 111) are never issued and are acked immediately with ctl_cmd=000, so the requester cannot hang.
- State BURST:
  - ctl_cmd=000 and ctl_din = owner's req_din.
  - In each cycle with ctl_notfull=1: req_dready[owner]=1 and counter decrements.
  - Counter 1→0 transition returns to ARB.
  - ctl_notfull=0 stalls the burst with no dready.
  - The owner must present the next beat combinationally; the arbiter never waits on the requester.
  - No other requester is granted during BURST.
- Return path:
  - On ctl_validout with a non-empty queue, one cycle later (registered):
    - rsp_valid[head.id]=1, rsp_data=ctl_dout, rsp_addr=ctl_raddr.
    - head.count decrements; the entry pops when the count reaches 0.
  - ctl_validout with an empty queue: the word is dropped and err_orphan is set; it clears only on reset.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Fairness:
  - A continuously requesting requester is served within NREQ grants.
  - A tag-full stall blocks only needs_tag winners; the search falls through to the next eligible requester, and the RR pointer is unchanged.

Decomposition:
- Package ddr2_arb_pkg:
  - cmd encoding constants (CMD_NOP, SCR, SCW, BLR, BLW, ATM0, ATM1).
  - needs_tag and ret_words functions.
  - State encoding: ARB, BURST.
- Sub-module ddr2_tag_queue:
  - Circular FIFO of {id[IDW-1:0], count[5:0]}.
  - push, pop-on-zero, decrement-head operations.
  - full and empty flags.
  - Simultaneous push and pop supported.

Test Plan:
- Both requesters continuously issue SCW, ctl_notfull=1 → acks alternate 0,1,0,1; ctl_cmd=010 every cycle; ctl_din matches the acked requester.
- Req0 BLW sz=1 while req1 is valid → exactly 16 beats on req0; the first beat is in the accept cycle and req_dready0 pulses 15 times; req1 is acked only after the last beat.
- ctl_notfull toggles 1,0,1 during BURST → dready suppressed in the 0 cycle; total beats still 16.
- Req0 BLR sz=0, then req1 SCR; drive 9 validouts → rsp_valid0 × 8, then rsp_valid1 × 1, each one cycle after validout, with data and address echoed.
- Fill 8 outstanding SCRs from req0 with no returns, then req0 SCR plus req1 SCW → req1 acked, req0 stalled; after one validout, req0 is acked.
- Validout with the queue empty → err_orphan=1 and no rsp_valid; assert reset mid-BURST → all outputs 0 immediately, state ARB.
